// File: rtl/alu_result_uart_tx.sv
// Buffers completed ALU results in a small FIFO and sends each one as a
// 7-byte 8N1 UART frame: A5, {opcode,00,error}, data MSB..LSB, XOR checksum.
module alu_result_uart_tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         res_valid,
  output logic                         res_ready,
  input  logic [3:0]                   res_opcode,
  input  logic [31:0]                  res_data,
  input  logic [1:0]                   res_error,
  output logic                         tx,
  output logic                         busy,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [37:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [37:0]   frameReg;
  logic [CW-1:0] baudCnt;
  logic [2:0]    bitIdx;
  logic [2:0]    byteIdx;
  logic          pushEn;
  logic          popEn;
  logic [7:0]    hdr;
  logic [7:0]    chk;
  logic [7:0]    curByte;

  // Handshake: a result transfers on a cycle where res_valid && res_ready;
  // res_ready depends only on the registered count, never on res_valid.
  assign res_ready = (fifo_count != FULL_CNT);
  assign pushEn    = res_valid && res_ready;
  assign popEn     = (state == IDLE) && (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (pushEn) mem[wrPtr] <= {res_opcode, res_error, res_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + 1'b1;
      if (popEn)  rdPtr <= rdPtr + 1'b1;
      case ({pushEn, popEn})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (res_valid && !res_ready) overflow <= 1'b1;
    end
  end

  // frameReg layout is {opcode[3:0], error[1:0], data[31:0]}.
  always_comb begin
    hdr = {frameReg[37:34], 2'b00, frameReg[33:32]};
    chk = hdr ^ frameReg[31:24] ^ frameReg[23:16] ^ frameReg[15:8] ^ frameReg[7:0];
    case (byteIdx)
      3'd0:    curByte = 8'hA5;
      3'd1:    curByte = hdr;
      3'd2:    curByte = frameReg[31:24];
      3'd3:    curByte = frameReg[23:16];
      3'd4:    curByte = frameReg[15:8];
      3'd5:    curByte = frameReg[7:0];
      default: curByte = chk;
    endcase
  end

  // tx is registered and changes on the same edge as the state, so each
  // bit (start and stop included) lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      baudCnt  <= '0;
      bitIdx   <= '0;
      byteIdx  <= '0;
      frameReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          busy    <= 1'b0;
          baudCnt <= '0;
          if (popEn) begin
            frameReg <= mem[rdPtr];
            byteIdx  <= '0;
            state    <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (baudCnt == CNT_MAX) begin
            baudCnt <= '0;
            bitIdx  <= '0;
            tx      <= curByte[0];
            state   <= DATA;
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        DATA: begin
          if (baudCnt == CNT_MAX) begin
            baudCnt <= '0;
            if (bitIdx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bitIdx <= bitIdx + 1'b1;
              tx     <= curByte[bitIdx + 3'd1];
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        STOP: begin
          if (baudCnt == CNT_MAX) begin
            baudCnt <= '0;
            if (byteIdx == 3'd6) begin
              state <= IDLE;
              tx    <= 1'b1;
              busy  <= 1'b0;
            end else begin
              byteIdx <= byteIdx + 1'b1;
              state   <= START;
              tx      <= 1'b0;
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Directed bench for alu_result_uart_tx: a UART decoder feeds whole frames to
// a scoreboard that pops hand-computed expected frames pushed by the driver.
module tb_alu_result_uart_tx;

  localparam int CPB       = 8;
  localparam int DEPTH     = 4;
  localparam int FRAME_CYC = 70 * CPB;
  localparam int HALF      = CPB / 2 - 1;

  logic        clk;
  logic        rst_n;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_opcode;
  logic [31:0] res_data;
  logic [1:0]  res_error;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [$clog2(DEPTH):0] fifo_count;

  alu_result_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_ready(res_ready),
    .res_opcode(res_opcode), .res_data(res_data), .res_error(res_error),
    .tx(tx), .busy(busy), .overflow(overflow), .fifo_count(fifo_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [55:0] exp_q[$];
  logic        chk_timing;
  int          last_busy_len;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // UART decoder + scoreboard; samples at mid-bit on falling clock edges
  initial begin
    logic        active;
    int          cnt;
    int          nbytes;
    logic [7:0]  sh;
    logic [55:0] frm;
    active = 1'b0; cnt = 0; nbytes = 0; sh = '0; frm = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
        nbytes = 0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1'b1;
          cnt    = 0;
        end
      end else begin
        cnt++;
        if (cnt == HALF) begin
          check("start bit level", tx, 1'b0);
        end else if (cnt > HALF && cnt < 9 * CPB + HALF && ((cnt - HALF) % CPB) == 0) begin
          sh = {tx, sh[7:1]};
        end else if (cnt == 9 * CPB + HALF) begin
          check("stop bit level", tx, 1'b1);
          active = 1'b0;
          frm    = {frm[47:0], sh};
          nbytes++;
          if (nbytes == 7) begin
            nbytes = 0;
            if (exp_q.size() == 0) begin
              n_vec++;
              n_fail++;
              $display("FAIL frame: got %h, required none queued", frm);
            end else begin
              check("frame", frm, exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  // busy-length and inter-frame gap tracker
  initial begin
    logic prev;
    int   blen;
    int   glen;
    prev = 1'b0; blen = 0; glen = 0; last_busy_len = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        if (!prev) begin
          if (chk_timing) check("idle gap", glen, 1);
          blen = 0;
        end
        blen++;
      end else begin
        if (prev) begin
          last_busy_len = blen;
          if (chk_timing) check("busy length", blen, FRAME_CYC);
          glen = 0;
        end
        glen++;
      end
      prev = busy;
    end
  end

  // driver tasks (called at a falling edge)
  task automatic set_res(input logic [3:0] op, input logic [1:0] err, input logic [31:0] d);
    res_opcode = op;
    res_error  = err;
    res_data   = d;
    res_valid  = 1'b1;
  endtask

  task automatic push_one(input logic [3:0] op, input logic [1:0] err, input logic [31:0] d,
                          input logic [55:0] frame);
    @(negedge clk);
    set_res(op, err, d);
    exp_q.push_back(frame);
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy !== 1'b0 || fifo_count != 0) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 6000) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s timeout: got busy=%0b count=%0d, required idle", name, busy, fifo_count);
    end
  endtask

  initial begin
    int         n;
    logic [7:0] seq;
    rst_n = 1'b0; res_valid = 1'b0; res_opcode = '0; res_data = '0; res_error = '0;
    chk_timing = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tx", tx, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset overflow", overflow, 1'b0);
    check("reset count", fifo_count, 0);
    check("reset ready", res_ready, 1'b1);
    rst_n = 1'b1;

    // single result with bit-level timing
    @(negedge clk);
    set_res(4'h3, 2'b00, 32'h12345678);
    exp_q.push_back(56'hA5_30_12345678_38);
    @(negedge clk);
    res_valid = 1'b0;
    check("count after push", fifo_count, 1);
    check("tx in push cycle", tx, 1'b1);
    @(negedge clk);
    check("tx falls", tx, 1'b0);
    check("busy at start", busy, 1'b1);
    check("count after pop", fifo_count, 0);
    n = 0;
    while (tx === 1'b0 && n < 100) begin n++; @(negedge clk); end
    check("start bit cycles", n, CPB);
    for (int j = 0; j < 8; j++) begin
      seq[7-j] = tx;
      repeat (CPB) @(negedge clk);
    end
    check("sync bit order", seq, 8'b10100101);
    n = 0;
    while (tx === 1'b1 && n < 100) begin n++; @(negedge clk); end
    check("stop bit cycles", n, CPB);
    wait_idle("single");
    check("single busy length", last_busy_len, FRAME_CYC);
    check("tx idle after frame", tx, 1'b1);

    // error frame
    push_one(4'hC, 2'b10, 32'h0, 56'hA5_C2_00000000_C2);
    wait_idle("error");

    // overflow burst, data 1..6
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 6) begin
        check("count full", fifo_count, DEPTH);
        check("ready when full", res_ready, 1'b0);
      end
      set_res(4'h1, 2'b00, 32'(k));
      if (k <= 5) exp_q.push_back({8'hA5, 8'h10, 32'(k), 8'h10 ^ 8'(k)});
    end
    @(negedge clk);
    res_valid = 1'b0;
    check("overflow set", overflow, 1'b1);
    check("count after drop", fifo_count, DEPTH);
    chk_timing = 1'b1;
    wait_idle("overflow");
    @(negedge clk);
    chk_timing = 1'b0;
    check("overflow sticky", overflow, 1'b1);

    // reset in the data bits of byte 3 with two entries queued
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_res(4'h5, 2'b01, 32'hAABBCCDD);
      exp_q.push_back(56'hA5_51_AABBCCDD_51);
    end
    @(negedge clk);
    res_valid = 1'b0;
    check("queued before reset", fifo_count, 2);
    repeat (280) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid reset tx", tx, 1'b1);
    check("mid reset busy", busy, 1'b0);
    check("mid reset count", fifo_count, 0);
    check("mid reset overflow", overflow, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) n++;
    end
    check("no frame after reset", n, 0);
    push_one(4'h7, 2'b11, 32'hDEADBEEF, 56'hA5_73_DEADBEEF_51);
    wait_idle("after reset");

    // push coinciding with the IDLE pop at count 2
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_res(4'h2, 2'b01, 32'hA0 + 32'(k * 16));
    end
    exp_q.push_back(56'hA5_21_000000A0_81);
    exp_q.push_back(56'hA5_21_000000B0_91);
    exp_q.push_back(56'hA5_21_000000C0_E1);
    @(negedge clk);
    res_valid = 1'b0;
    check("count before pop", fifo_count, 2);
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    check("idle reached", n < 2000, 1'b1);
    check("count at idle", fifo_count, 2);
    set_res(4'h2, 2'b01, 32'hD0);
    exp_q.push_back(56'hA5_21_000000D0_F1);
    @(negedge clk);
    res_valid = 1'b0;
    check("count push+pop", fifo_count, 2);
    wait_idle("push pop");

    check("frames outstanding", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_uart_tx.md
Name: alu_result_uart_tx

Overview:
Return path from the ALU to the Python middleware. It accepts one completed ALU result per handshake: the 32-bit result, the 4-bit opcode that produced it, and the 2-bit error code. Results are buffered in a small FIFO. Each result is serialized as a fixed 7-byte UART frame, so the middleware reads back what its commands produced.

Parameters:
CLKS_PER_BIT, 8, clock cycles per UART bit (minimum 2).
FIFO_DEPTH, 4, number of buffered result entries (power of two, minimum 2).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
res_valid  input  1  producer presents a result this cycle.
res_ready  output  1  block accepts a result this cycle; equals !fifo_full.
res_opcode  input  4  opcode that produced the result.
res_data  input  32  ALU output value.
res_error  input  2  ALU error code.
tx  output  1  UART serial line, idle high.
busy  output  1  high while a frame is being shifted out.
overflow  output  1  sticky; set when res_valid=1 while res_ready=0.
fifo_count  output  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.

Behaviour:
- Reset (asserted): tx=1, busy=0, overflow=0, fifo_count=0, FSM=IDLE, pointers=0. This takes effect immediately and asynchronously, including in the middle of a frame. A frame in progress is discarded, not resumed.
- Push: an entry {opcode, error, data} is written when res_valid && res_ready. res_ready is derived from the registered count only.
  - When full, a push is refused even if a pop happens in the same cycle.
  - When not full, a simultaneous push and pop leaves the count unchanged.
- Overflow: res_valid while full sets overflow. The entry is dropped and FIFO contents are unchanged. overflow is cleared only by reset.
- Frame format, bytes in order:
  - 0xA5 (sync)
  - HDR = {opcode[3:0], 2'b00, error[1:0]}
  - data[31:24], data[23:16], data[15:8], data[7:0]
  - CHK = XOR of HDR and the four data bytes
- Bytes are sent 8N1, LSB first. Each bit, including start and stop, holds for exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, busy=0. If fifo_count!=0, pop the head into the frame register and set byte_idx=0. Go to START, so tx falls on the next edge. No bypass: a result pushed into an empty FIFO starts transmitting 1 cycle after the push cycle.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=byte[bit_idx] for CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If byte_idx<6: increment byte_idx and go to START, with no extra idle between bytes.
    - If byte_idx=6: go to IDLE.
- busy=1 in START, DATA and STOP.
- Timing:
  - Frame length = 70*CLKS_PER_BIT cycles.
  - Back-to-back frames are separated by exactly one IDLE cycle of tx=1 after the final stop bit.
- Counters: the baud counter is $clog2(CLKS_PER_BIT) bits and wraps 0..CLKS_PER_BIT-1. Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- Changes to res_* while res_ready=0 or res_valid=0 have no effect.

Test Plan:
- Single result, CLKS_PER_BIT=8:
  - Stimulus: opcode=4'h3, error=2'b00, data=32'h12345678, one-cycle valid.
  - Required bytes: A5 30 12 34 56 78 38.
  - tx falls 1 cycle after the push cycle; busy is high for 560 cycles; tx=1 afterward.
- Error frame:
  - Stimulus: opcode=4'hC, error=2'b10, data=0.
  - Required bytes: A5 C2 00 00 00 00 C2.
- Bit timing:
  - Start bit is low for exactly 8 cycles.
  - Sync-byte data bits, in transmit order, are 1,0,1,0,0,1,0,1.
  - Stop bit is high for 8 cycles; the next start bit follows immediately.
- Overflow, FIFO_DEPTH=4:
  - Stimulus: res_valid=1 for 6 consecutive cycles starting idle, data=1..6.
  - Pushes 1–5 are accepted (first one popped to TX); fifo_count reaches 4 and res_ready=0 on the 6th cycle.
  - Push 6 is dropped and overflow=1.
  - Frames carry data 1,2,3,4,5 in order, each separated by 1 idle cycle.
- Reset mid-frame:
  - Stimulus: drop rst_n during the DATA bits of byte 3 with 2 entries queued.
  - Required: tx=1, busy=0, fifo_count=0 and overflow=0 immediately, with no further frames.
  - After release, a new push produces a complete correct frame.
- Simultaneous push/pop:
  - Stimulus: push while IDLE pops with fifo_count=2.
  - Required: count stays 2 and data order is preserved.
